// File: rtl/pe_grid_seq.sv
// Multi-row signed MAC array: each row is a COLS-tap chain with serial weight load,
// fill tracking, bypass, arithmetic shift, saturation and optional ReLU.
module pe_grid_seq #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int N     = 4,
  parameter int M     = 4,
  parameter int ACC_W = N + M + $clog2(COLS),
  parameter int SR    = 2,
  parameter int RELU  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ROWS*N-1:0] d_in,
  input  logic [ROWS-1:0]   en_in,
  input  logic [ROWS*M-1:0] w_in,
  input  logic              w_conf,
  input  logic              cntl_conf,
  input  logic [ROWS-1:0]   bp_in,
  output logic [ROWS*N-1:0] d_out,
  output logic [ROWS-1:0]   en_out,
  output logic              w_ready
);

  localparam int CW = $clog2(COLS + 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (N - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic {CFG, RUN} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   load_cnt, load_cnt_nxt;
  logic            fill_clr;
  logic [ROWS-1:0] bp;

  logic signed [M-1:0] w      [ROWS][COLS];
  logic signed [N-1:0] tap_p0 [ROWS][COLS];
  logic [CW-1:0]       fill   [ROWS];

  logic signed [N-1:0]     tap_nxt  [ROWS][COLS];
  logic [CW-1:0]           fill_nxt [ROWS];
  logic signed [ACC_W-1:0] acc      [ROWS];
  logic signed [N-1:0]     res      [ROWS];
  logic [ROWS-1:0]         accept, fire;

  logic signed [N-1:0] dout_p1 [ROWS];
  logic [ROWS-1:0]     vld_p1;

  function automatic logic signed [N-1:0] sat_n(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX)      return SAT_MAX[N-1:0];
    else if (v < SAT_MIN) return SAT_MIN[N-1:0];
    else                  return v[N-1:0];
  endfunction

  function automatic logic signed [N-1:0] relu_n(input logic signed [N-1:0] v);
    return (RELU != 0 && v[N-1]) ? '0 : v;
  endfunction

  assign w_ready = (state == RUN);

  // Weight-load sequencing; a reload from RUN counts as the first shift.
  always_comb begin
    state_nxt    = state;
    load_cnt_nxt = load_cnt;
    fill_clr     = cntl_conf;
    case (state)
      CFG: begin
        if (w_conf) begin
          if (load_cnt == CW'(COLS - 1)) begin
            state_nxt    = RUN;
            load_cnt_nxt = CW'(COLS);
          end else begin
            load_cnt_nxt = load_cnt + CW'(1);
          end
        end
      end
      RUN: begin
        if (w_conf) begin
          state_nxt    = (COLS == 1) ? RUN : CFG;
          load_cnt_nxt = CW'(1);
          fill_clr     = 1'b1;
        end
      end
      default: state_nxt = CFG;
    endcase
  end

  always_comb begin
    for (int j = 0; j < ROWS; j++) begin
      accept[j]     = en_in[j] & ~bp[j] & w_ready & ~w_conf;
      tap_nxt[j][0] = d_in[j*N +: N];
      for (int i = 1; i < COLS; i++) tap_nxt[j][i] = tap_p0[j][i-1];
      // Clear takes priority so a same-cycle enable counts as fill 1.
      fill_nxt[j] = fill_clr ? '0 : fill[j];
      if (accept[j] && fill_nxt[j] != CW'(COLS)) fill_nxt[j] = fill_nxt[j] + CW'(1);
      fire[j] = accept[j] && (fill_nxt[j] == CW'(COLS));
      acc[j]  = '0;
      for (int i = 0; i < COLS; i++)
        acc[j] = acc[j] + ACC_W'(tap_nxt[j][i]) * ACC_W'(w[j][i]);
      res[j] = relu_n(sat_n(acc[j] >>> SR));
    end
  end

  // stage 0 -> 1: tap shift, MAC result and bypass data registered to outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CFG;
      load_cnt <= '0;
      bp       <= '0;
      vld_p1   <= '0;
      for (int j = 0; j < ROWS; j++) begin
        fill[j]    <= '0;
        dout_p1[j] <= '0;
        for (int i = 0; i < COLS; i++) begin
          w[j][i]      <= '0;
          tap_p0[j][i] <= '0;
        end
      end
    end else begin
      state    <= state_nxt;
      load_cnt <= load_cnt_nxt;
      if (cntl_conf) bp <= bp_in;
      for (int j = 0; j < ROWS; j++) begin
        fill[j] <= fill_nxt[j];
        if (w_conf) begin
          w[j][0] <= w_in[j*M +: M];
          for (int i = 1; i < COLS; i++) w[j][i] <= w[j][i-1];
        end
        if (accept[j]) begin
          for (int i = 0; i < COLS; i++) tap_p0[j][i] <= tap_nxt[j][i];
        end
        if (bp[j]) begin
          vld_p1[j]  <= en_in[j];
          dout_p1[j] <= d_in[j*N +: N];
        end else begin
          vld_p1[j] <= fire[j];
          if (fire[j]) dout_p1[j] <= res[j];
        end
      end
    end
  end

  assign en_out = vld_p1;

  for (genvar j = 0; j < ROWS; j++) begin : g_out
    assign d_out[j*N +: N] = dout_p1[j];
  end

endmodule

// File: tb/tb_pe_grid_seq.sv
// Directed bench for pe_grid_seq: a behavioural row model queues expected outputs
// per driven cycle; two instances cover RELU=1 and RELU=0.
module tb_pe_grid_seq;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int N    = 4;
  localparam int M    = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [ROWS*N-1:0] d_in;
  logic [ROWS-1:0]   en_in;
  logic [ROWS*M-1:0] w_in;
  logic              w_conf, cntl_conf;
  logic [ROWS-1:0]   bp_in;
  logic [ROWS*N-1:0] d_out, d_out_nr;
  logic [ROWS-1:0]   en_out, en_out_nr;
  logic              w_ready, w_ready_nr;

  pe_grid_seq #(.ROWS(ROWS), .COLS(COLS), .N(N), .M(M), .SR(2), .RELU(1)) u_dut (
    .clk(clk), .rst(rst), .d_in(d_in), .en_in(en_in), .w_in(w_in), .w_conf(w_conf),
    .cntl_conf(cntl_conf), .bp_in(bp_in), .d_out(d_out), .en_out(en_out), .w_ready(w_ready));

  pe_grid_seq #(.ROWS(ROWS), .COLS(COLS), .N(N), .M(M), .SR(2), .RELU(0)) u_dut_nr (
    .clk(clk), .rst(rst), .d_in(d_in), .en_in(en_in), .w_in(w_in), .w_conf(w_conf),
    .cntl_conf(cntl_conf), .bp_in(bp_in), .d_out(d_out_nr), .en_out(en_out_nr),
    .w_ready(w_ready_nr));

  typedef struct {
    logic [ROWS*N-1:0] d;
    logic [ROWS*N-1:0] d_nr;
    logic [ROWS-1:0]   en;
    logic              wr;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  int                mw   [ROWS][COLS];
  int                mtap [ROWS][COLS];
  int                mfill[ROWS];
  bit                mbp  [ROWS];
  int                mcnt;
  bit                mrun;
  logic [ROWS*N-1:0] md, md_nr;
  logic [ROWS-1:0]   men;

  function automatic int scale(input int s, input bit relu);
    int v;
    v = s >>> 2;
    if (v > 7)  v = 7;
    if (v < -8) v = -8;
    if (relu && v < 0) v = 0;
    return v;
  endfunction

  function automatic logic [ROWS*N-1:0] pk(input int a0, input int a1, input int a2, input int a3);
    return {N'(a3), N'(a2), N'(a1), N'(a0)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_push();
    bit clear, acc;
    int f, sum;
    exp_t e;
    if (rst) begin
      for (int j = 0; j < ROWS; j++) begin
        mfill[j] = 0;
        mbp[j]   = 0;
        for (int i = 0; i < COLS; i++) begin
          mw[j][i]   = 0;
          mtap[j][i] = 0;
        end
      end
      mcnt = 0; mrun = 0; md = '0; md_nr = '0; men = '0;
    end else begin
      clear = cntl_conf || (mrun && w_conf);
      for (int j = 0; j < ROWS; j++) begin
        if (mbp[j]) begin
          men[j]          = en_in[j];
          md[j*N +: N]    = d_in[j*N +: N];
          md_nr[j*N +: N] = d_in[j*N +: N];
          if (clear) mfill[j] = 0;
        end else begin
          acc    = en_in[j] && mrun && !w_conf;
          f      = clear ? 0 : mfill[j];
          men[j] = 1'b0;
          if (acc) begin
            for (int i = COLS - 1; i > 0; i--) mtap[j][i] = mtap[j][i-1];
            mtap[j][0] = $signed(d_in[j*N +: N]);
            if (f < COLS) f++;
            if (f == COLS) begin
              sum = 0;
              for (int i = 0; i < COLS; i++) sum += mtap[j][i] * mw[j][i];
              md[j*N +: N]    = N'(scale(sum, 1'b1));
              md_nr[j*N +: N] = N'(scale(sum, 1'b0));
              men[j]          = 1'b1;
            end
          end
          mfill[j] = f;
        end
      end
      if (w_conf) begin
        for (int j = 0; j < ROWS; j++) begin
          for (int i = COLS - 1; i > 0; i--) mw[j][i] = mw[j][i-1];
          mw[j][0] = $signed(w_in[j*M +: M]);
        end
        if (mrun) begin
          mrun = 0; mcnt = 1;
        end else begin
          mcnt++;
          if (mcnt == COLS) mrun = 1;
        end
      end
      if (cntl_conf) for (int j = 0; j < ROWS; j++) mbp[j] = bp_in[j];
    end
    e.d = md; e.d_nr = md_nr; e.en = men; e.wr = mrun;
    sb.push_back(e);
  endtask

  task automatic step(input string tag);
    exp_t e;
    model_push();
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".d_out"},      d_out,      e.d);
    chk({tag, ".en_out"},     en_out,     e.en);
    chk({tag, ".w_ready"},    w_ready,    e.wr);
    chk({tag, ".d_out_nr"},   d_out_nr,   e.d_nr);
    chk({tag, ".en_out_nr"},  en_out_nr,  e.en);
    chk({tag, ".w_ready_nr"}, w_ready_nr, e.wr);
  endtask

  task automatic load_w(input int v, input string tag);
    w_conf = 1'b1;
    w_in   = pk(v, v, v, v);
    for (int k = 0; k < COLS; k++) step(tag);
    w_conf = 1'b0;
  endtask

  initial begin
    rst = 1'b1; d_in = '0; en_in = '0; w_in = '0;
    w_conf = 1'b0; cntl_conf = 1'b0; bp_in = '0;
    step("reset");
    chk("reset_dout", d_out, '0);
    chk("reset_ready", w_ready, 1'b0);
    rst = 1'b0;

    // Weight load 1,2 then pause, then 3,4
    w_conf = 1'b1;
    w_in = pk(1, 1, 1, 1); step("wl1");
    w_in = pk(2, 2, 2, 2); step("wl2");
    w_conf = 1'b0;
    step("wl_hold"); step("wl_hold");
    chk("ready_low_hold", w_ready, 1'b0);
    w_conf = 1'b1;
    w_in = pk(3, 3, 3, 3); step("wl3");
    chk("ready_low_3", w_ready, 1'b0);
    w_in = pk(4, 4, 4, 4); step("wl4");
    chk("ready_up", w_ready, 1'b1);
    w_conf = 1'b0;

    // Weight order probe on row 0
    en_in = 4'b0001;
    d_in = pk(4, 0, 0, 0); step("probe");
    d_in = pk(0, 0, 0, 0); step("probe"); step("probe"); step("probe");
    chk("w3_first_loaded", d_out[3:0], 4'd1);
    step("probe");
    d_in = pk(4, 0, 0, 0); step("probe");
    chk("w0_last_loaded", d_out[3:0], 4'd4);

    // Reload with all ones; enables during reload are ignored
    en_in = 4'b0001; d_in = pk(3, 0, 0, 0);
    w_conf = 1'b1; w_in = pk(1, 1, 1, 1);
    step("reload1");
    chk("reload_ready_low", w_ready, 1'b0);
    chk("reload_en_ignored", en_out[0], 1'b0);
    step("reload"); step("reload"); step("reload");
    w_conf = 1'b0;

    // Basic MAC, row 0 positive and row 2 negative
    en_in = 4'b0101;
    for (int k = 1; k <= 4; k++) begin
      d_in = pk(k, 0, -k, 0);
      step("mac");
      if (k == 3) chk("mac_not_full", en_out, 4'b0000);
    end
    chk("mac_sum10", d_out[3:0], 4'd2);
    chk("mac_en", en_out[0], 1'b1);
    chk("mac_relu_neg", d_out[11:8], 4'd0);
    chk("mac_norelu_neg", d_out_nr[11:8], 4'hD);
    en_in = 4'b0001; d_in = pk(5, 0, 0, 0);
    step("mac5");
    chk("mac_sum14", d_out[3:0], 4'd3);
    en_in = 4'b0000;
    step("idle");
    chk("idle_en_low", en_out, 4'b0000);
    chk("idle_hold", d_out[3:0], 4'd3);

    // Saturation high and low
    load_w(7, "w7");
    en_in = 4'b0001; d_in = pk(7, 0, 0, 0);
    for (int k = 0; k < 4; k++) step("sat_hi");
    chk("sat_hi", d_out[3:0], 4'd7);
    load_w(1, "w1");
    d_in = pk(-8, 0, 0, 0);
    for (int k = 0; k < 4; k++) step("sat_lo");
    chk("sat_lo_relu", d_out[3:0], 4'd0);
    chk("sat_lo_norelu", d_out_nr[3:0], 4'h8);

    // cntl_conf with same-cycle enable: accepted with old bypass, fill restarts at 1
    cntl_conf = 1'b1; bp_in = 4'b0010;
    en_in = 4'b0011; d_in = pk(1, 6, 0, 0);
    step("conf");
    cntl_conf = 1'b0;
    en_in = 4'b0001; d_in = pk(1, 2, 0, 0); step("fill2");
    en_in = 4'b0011; d_in = pk(1, 5, 0, 0); step("fill3");
    chk("fill_after_conf", en_out[0], 1'b0);
    chk("bypass_run", d_out[7:4], 4'd5);
    en_in = 4'b0001; d_in = pk(1, -3, 0, 0); step("fill4");
    chk("fill_fire", d_out[3:0], 4'd1);
    chk("bypass_en_follow", en_out[1], 1'b0);

    // Bypass continues while reloading (w_ready low); row 0 idle
    w_conf = 1'b1; w_in = pk(1, 1, 1, 1);
    for (int k = 0; k < 4; k++) begin
      en_in = 4'b0011; d_in = pk(2, k - 2, 0, 0);
      step("bp_load");
      if (k == 0) begin
        chk("bp_ready_low", w_ready, 1'b0);
        chk("bp_follow", d_out[7:4], 4'hE);
        chk("bp_row0_idle", en_out[0], 1'b0);
      end
    end
    w_conf = 1'b0;
    cntl_conf = 1'b1; bp_in = 4'b0000;
    en_in = 4'b0010; d_in = pk(0, 7, 0, 0);
    step("bp_off");
    cntl_conf = 1'b0; en_in = 4'b0010;
    step("bp_gone");
    chk("bp_off_en", en_out[1], 1'b0);

    // Reset mid-stream
    en_in = 4'b0001; d_in = pk(3, 0, 0, 0);
    step("pre_rst"); step("pre_rst");
    rst = 1'b1;
    step("mid_rst");
    chk("mid_rst_dout", d_out, '0);
    chk("mid_rst_ready", w_ready, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) step("post_rst");
    chk("post_rst_ignored", en_out, 4'b0000);
    load_w(1, "w_after_rst");
    d_in = pk(2, 0, 0, 0);
    for (int k = 0; k < 4; k++) step("after_rst");
    chk("after_rst_mac", d_out[3:0], 4'd2);
    en_in = 4'b0000;
    step("end");

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
